bytes_screen_decoder: RTL and testbench
=======================================

# bytes_screen_decoder

Receive-side parser for the bytes-screen debug stream. Consumes the byte stream from a UART receiver and locks onto the framed packet "WAVWID" + width + "OSCIDX" + 4 oscillator indices + "WAVDAT" + samples. It then republishes the wave width and oscillator indices and emits one write strobe per 16-bit sample. It sits behind `uart_receive` on a loopback or second-board build and feeds a sample BRAM plus the status registers.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles allowed between bytes inside a frame before abort.

Localparams (protocol-fixed):
- `NUM_OSCILLATORS` = 4
- `WW_WIDTH` = 18
- `SAMPLE_WIDTH` = 16

Ports:
- `clk_in`  in  1  system clock (100 MHz); the only clock.
- `rst_in`  in  1  reset; asynchronous, active-low.
- `rx_valid_in`  in  1  one-cycle strobe; `rx_byte_in` valid.
- `rx_byte_in`  in  8  received byte.
- `wave_width_out`  out  18  width from the last complete frame.
- `osc_indices_out`  out  [4][18]  oscillator indices from the last complete frame.
- `sample_valid_out`  out  1  one-cycle strobe per decoded sample.
- `sample_index_out`  out  18  sample position within the frame, 0-based.
- `sample_data_out`  out  16  decoded sample.
- `frame_done_out`  out  1  one-cycle pulse; frame completed and outputs published.
- `frame_error_out`  out  1  one-cycle pulse; frame aborted.
- `error_count_out`  out  8  saturating count of aborts.

## Operation
Wire format:
- Headers are ASCII, first byte first.
- Each 18-bit field is 3 bytes, big-endian. The first byte is {6'b0, f[17:16]}, then f[15:8], then f[7:0].
- Each sample is 2 bytes, big-endian.
- Sample count equals the decoded width.

States:
- HUNT: 6-byte sliding window. On a window equal to "WAVWID", go to WW and clear the window.
- WW: 3 bytes into the staging width, then go to OSC_HDR.
- OSC_HDR: 6 bytes, each compared against "OSCIDX" in order.
- OSC: 12 bytes into staging indices 0..3, then go to DAT_HDR.
- DAT_HDR: 6 bytes compared against "WAVDAT". Go to DAT, or straight to DONE if the staging width is 0.
- DAT: byte pairs. The second byte of each pair fires a sample strobe with an incrementing index. After sample width−1, go to DONE.
- DONE: single cycle. Copy staging to `wave_width_out`/`osc_indices_out`, pulse `frame_done_out`, go to HUNT.

Abort conditions (all abort paths pulse `frame_error_out`, saturate-increment `error_count_out`, and go to HUNT):
- A header byte mismatches. The mismatching byte is loaded as the newest byte of the fresh HUNT window, so a new frame start is not lost.
- The first byte of an 18-bit field has bits [7:2] ≠ 0.
- The timeout expires.

Other rules:
- An abort never updates the published width or indices. Samples already strobed remain written.
- A new "WAVWID" appearing inside WW/OSC/DAT payload is treated as data (no resync).

## Timing
- Reset values: all outputs 0; state HUNT; window, staging, counters 0.
- A byte is consumed in the cycle `rx_valid_in` is high. Back-to-back bytes every cycle must be accepted.
- `sample_valid_out`/`sample_index_out`/`sample_data_out` are registered and appear 1 cycle after the second byte of the pair.
- `frame_done_out` asserts 1 cycle after the last sample strobe, or 2 cycles after the last "WAVDAT" byte when the width is 0.
- Published outputs change in the same cycle `frame_done_out` is high.
- The error pulse asserts 1 cycle after the offending byte or timeout.
- Reset asserted mid-frame returns to the reset values immediately, with no pulses.

## Configuration
- `BYTES_SCREEN_DECODER_TIMEOUT_EN` defined: a counter runs in every state except HUNT.
  - It clears on each accepted byte.
  - Reaching `TIMEOUT_CYCLES` aborts the frame.
  - If `rx_valid_in` arrives in the same cycle the limit is reached, the byte wins and the counter clears.
- Not defined: no counter is built, and a stalled frame waits indefinitely.

## Test plan
- Full frame, width 3, indices 1/2/3/0x3FFFF, samples 0x1234/0xABCD/0x0001 -> three strobes (index 0,1,2 with those data), then `frame_done_out`; outputs publish width 3 and the four indices.
- Garbage "WAVWAVWID" prefix, then a valid width-1 frame -> lock on the correct "WAVWID"; one sample; no error.
- "OSCIDY" in place of "OSCIDX" -> `frame_error_out` after 'Y'; count 1; published values unchanged. A following valid frame decodes correctly.
- Width byte 0x04 (bit 2 set) -> abort; count increments.
- Width 0 frame -> no sample strobes; done 2 cycles after the final 'T'; `wave_width_out` = 0.
- Timeout (macro defined, `TIMEOUT_CYCLES`=50): stall after the 2nd sample byte pair starts -> error at cycle 50. A byte arriving on exactly cycle 50 -> no error.

Source files
------------

// File: rtl/bytes_screen_decoder.sv
// Bytes-screen receive parser: locks onto "WAVWID"/"OSCIDX"/"WAVDAT" frames and strobes out 16-bit samples.
// Optional inter-byte timeout abort is built when BYTES_SCREEN_DECODER_TIMEOUT_EN is defined.
module bytes_screen_decoder #(
    parameter int  TIMEOUT_CYCLES  = 1_000_000,
    localparam int NUM_OSCILLATORS = 4,
    localparam int WW_WIDTH        = 18,
    localparam int SAMPLE_WIDTH    = 16
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    rx_valid_in,
    input  logic [7:0]                              rx_byte_in,
    output logic [WW_WIDTH-1:0]                     wave_width_out,
    output logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0] osc_indices_out,
    output logic                                    sample_valid_out,
    output logic [WW_WIDTH-1:0]                     sample_index_out,
    output logic [SAMPLE_WIDTH-1:0]                 sample_data_out,
    output logic                                    frame_done_out,
    output logic                                    frame_error_out,
    output logic [7:0]                              error_count_out
);

    localparam logic [2:0] S_HUNT    = 3'd0;
    localparam logic [2:0] S_WW      = 3'd1;
    localparam logic [2:0] S_OSC_HDR = 3'd2;
    localparam logic [2:0] S_OSC     = 3'd3;
    localparam logic [2:0] S_DAT_HDR = 3'd4;
    localparam logic [2:0] S_DAT     = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [47:0] WAVWID_STR = "WAVWID";
    localparam logic [47:0] OSCIDX_STR = "OSCIDX";
    localparam logic [47:0] WAVDAT_STR = "WAVDAT";

    logic [2:0]                               state;
    logic [47:0]                              window;
    logic [47:0]                              win_next;
    logic [2:0]                               hdr_cnt;
    logic [1:0]                               pos;
    logic [1:0]                               fld;
    logic [7:0]                               samp_hi;
    logic [WW_WIDTH-1:0]                      samp_cnt;
    logic [WW_WIDTH-1:0]                      stg_width;
    logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0] stg_osc;
    logic [7:0]                               exp_byte;
    logic                                     hdr_bad;
    logic                                     fld_bad;
    logic                                     tmo_hit;

    // Header strings are stored first-character-in-MSB; byte i of the header.
    function automatic logic [7:0] hdr_byte(input logic [47:0] s, input logic [2:0] i);
        logic [47:0] t;
        t = s << {i, 3'b000};
        return t[47:40];
    endfunction

    always_comb begin
        exp_byte = 8'h00;
        case (state)
            S_OSC_HDR: exp_byte = hdr_byte(OSCIDX_STR, hdr_cnt);
            S_DAT_HDR: exp_byte = hdr_byte(WAVDAT_STR, hdr_cnt);
            default:   exp_byte = 8'h00;
        endcase
        hdr_bad  = rx_valid_in && (state == S_OSC_HDR || state == S_DAT_HDR) && (rx_byte_in != exp_byte);
        fld_bad  = rx_valid_in && (state == S_WW || state == S_OSC) && (pos == 2'd0) && (rx_byte_in[7:2] != 6'd0);
        win_next = {window[39:0], rx_byte_in};
    end

`ifdef BYTES_SCREEN_DECODER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // An arriving byte on the limit cycle wins over the timeout.
    assign tmo_hit = (state != S_HUNT) && !rx_valid_in && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tmo_cnt <= '0;
        end else if (state == S_HUNT || rx_valid_in || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= S_HUNT;
            window           <= '0;
            hdr_cnt          <= '0;
            pos              <= '0;
            fld              <= '0;
            samp_hi          <= '0;
            samp_cnt         <= '0;
            stg_width        <= '0;
            stg_osc          <= '0;
            wave_width_out   <= '0;
            osc_indices_out  <= '0;
            sample_valid_out <= 1'b0;
            sample_index_out <= '0;
            sample_data_out  <= '0;
            frame_done_out   <= 1'b0;
            frame_error_out  <= 1'b0;
            error_count_out  <= '0;
        end else begin
            sample_valid_out <= 1'b0;
            frame_done_out   <= 1'b0;
            frame_error_out  <= 1'b0;
            if (hdr_bad || fld_bad || tmo_hit) begin
                frame_error_out <= 1'b1;
                if (error_count_out != 8'hFF) error_count_out <= error_count_out + 8'd1;
                state    <= S_HUNT;
                // A mismatching header byte may itself start the next "WAVWID".
                window   <= hdr_bad ? {40'd0, rx_byte_in} : 48'd0;
                hdr_cnt  <= '0;
                pos      <= '0;
                fld      <= '0;
                samp_cnt <= '0;
            end else begin
                case (state)
                    S_HUNT: if (rx_valid_in) begin
                        if (win_next == WAVWID_STR) begin
                            state  <= S_WW;
                            window <= '0;
                            pos    <= '0;
                        end else begin
                            window <= win_next;
                        end
                    end
                    S_WW: if (rx_valid_in) begin
                        stg_width <= {stg_width[9:0], rx_byte_in};
                        if (pos == 2'd2) begin
                            pos     <= '0;
                            hdr_cnt <= '0;
                            state   <= S_OSC_HDR;
                        end else begin
                            pos <= pos + 2'd1;
                        end
                    end
                    S_OSC_HDR: if (rx_valid_in) begin
                        if (hdr_cnt == 3'd5) begin
                            hdr_cnt <= '0;
                            pos     <= '0;
                            fld     <= '0;
                            state   <= S_OSC;
                        end else begin
                            hdr_cnt <= hdr_cnt + 3'd1;
                        end
                    end
                    S_OSC: if (rx_valid_in) begin
                        stg_osc[fld] <= {stg_osc[fld][9:0], rx_byte_in};
                        if (pos == 2'd2) begin
                            pos <= '0;
                            if (fld == 2'd3) begin
                                fld     <= '0;
                                hdr_cnt <= '0;
                                state   <= S_DAT_HDR;
                            end else begin
                                fld <= fld + 2'd1;
                            end
                        end else begin
                            pos <= pos + 2'd1;
                        end
                    end
                    S_DAT_HDR: if (rx_valid_in) begin
                        if (hdr_cnt == 3'd5) begin
                            hdr_cnt  <= '0;
                            pos      <= '0;
                            samp_cnt <= '0;
                            state    <= (stg_width == '0) ? S_DONE : S_DAT;
                        end else begin
                            hdr_cnt <= hdr_cnt + 3'd1;
                        end
                    end
                    S_DAT: if (rx_valid_in) begin
                        if (!pos[0]) begin
                            samp_hi <= rx_byte_in;
                            pos     <= 2'd1;
                        end else begin
                            pos              <= '0;
                            sample_valid_out <= 1'b1;
                            sample_index_out <= samp_cnt;
                            sample_data_out  <= {samp_hi, rx_byte_in};
                            if (samp_cnt == stg_width - 18'd1) begin
                                samp_cnt <= '0;
                                state    <= S_DONE;
                            end else begin
                                samp_cnt <= samp_cnt + 18'd1;
                            end
                        end
                    end
                    S_DONE: begin
                        wave_width_out  <= stg_width;
                        osc_indices_out <= stg_osc;
                        frame_done_out  <= 1'b1;
                        state           <= S_HUNT;
                        if (rx_valid_in) window <= {40'd0, rx_byte_in};
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bytes_screen_decoder.sv
// Directed self-checking bench for bytes_screen_decoder: framing, aborts, width-0 and stall/timeout behaviour.
module tb_bytes_screen_decoder;

    logic             clk;
    logic             rst_n;
    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic [17:0]      wave_width;
    logic [3:0][17:0] osc_indices;
    logic             sample_valid;
    logic [17:0]      sample_index;
    logic [15:0]      sample_data;
    logic             frame_done;
    logic             frame_error;
    logic [7:0]       error_count;

    bytes_screen_decoder #(.TIMEOUT_CYCLES(50)) dut (
        .clk_in           (clk),
        .rst_in           (rst_n),
        .rx_valid_in      (rx_valid),
        .rx_byte_in       (rx_byte),
        .wave_width_out   (wave_width),
        .osc_indices_out  (osc_indices),
        .sample_valid_out (sample_valid),
        .sample_index_out (sample_index),
        .sample_data_out  (sample_data),
        .frame_done_out   (frame_done),
        .frame_error_out  (frame_error),
        .error_count_out  (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_byte_cyc = 0;
    int strobe_cyc = 0;
    int done_cyc = 0;
    int err_cyc = 0;
    int done_n = 0;
    int err_n = 0;
    int strobe_n = 0;
    logic [33:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each strobe must match the next queued {index, data}.
    always @(posedge clk) begin
        logic [33:0] e;
        #1;
        if (sample_valid) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
            check("sample", {sample_index, sample_data}, e);
            strobe_cyc = cyc;
            strobe_n++;
        end
        if (frame_done) begin
            done_cyc = cyc;
            done_n++;
        end
        if (frame_error) begin
            err_cyc = cyc;
            err_n++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte = b;
        last_byte_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_field(input logic [17:0] f);
        send_byte({6'd0, f[17:16]});
        send_byte(f[15:8]);
        send_byte(f[7:0]);
    endtask

    task automatic send_head(input logic [17:0] w, input logic [3:0][17:0] osc);
        send_str("WAVWID");
        send_field(w);
        send_str("OSCIDX");
        for (int i = 0; i < 4; i++) send_field(osc[i]);
        send_str("WAVDAT");
    endtask

    task automatic send_sample(input logic [17:0] idx, input logic [15:0] d);
        exp_q.push_back({idx, d});
        send_byte(d[15:8]);
        send_byte(d[7:0]);
    endtask

    int d0, e0, s0;

    initial begin
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_width", wave_width, 18'd0);
        check("rst_osc", osc_indices, 72'd0);
        check("rst_pulses", {sample_valid, frame_done, frame_error}, 3'b000);
        check("rst_errcnt", error_count, 8'd0);
        rst_n = 1'b1;
        idle(2);

        // Full width-3 frame.
        d0 = done_n; e0 = err_n;
        send_head(18'd3, {18'h3FFFF, 18'd3, 18'd2, 18'd1});
        send_sample(18'd0, 16'h1234);
        send_sample(18'd1, 16'hABCD);
        send_sample(18'd2, 16'h0001);
        idle(4);
        check("f3_done", done_n - d0, 1);
        check("f3_err", err_n - e0, 0);
        check("f3_strobe_lat", strobe_cyc - last_byte_cyc, 0);
        check("f3_done_lat", done_cyc - strobe_cyc, 1);
        check("f3_width", wave_width, 18'd3);
        check("f3_osc0", osc_indices[0], 18'd1);
        check("f3_osc1", osc_indices[1], 18'd2);
        check("f3_osc2", osc_indices[2], 18'd3);
        check("f3_osc3", osc_indices[3], 18'h3FFFF);
        check("f3_q", exp_q.size(), 0);

        // Garbage "WAV" prefix forming "WAVWAVWID", then a width-1 frame.
        d0 = done_n; e0 = err_n; s0 = strobe_n;
        send_str("WAV");
        send_head(18'd1, {18'd40, 18'd30, 18'd20, 18'd10});
        send_sample(18'd0, 16'h7E57);
        idle(4);
        check("pre_done", done_n - d0, 1);
        check("pre_err", err_n - e0, 0);
        check("pre_strobes", strobe_n - s0, 1);
        check("pre_width", wave_width, 18'd1);
        check("pre_osc2", osc_indices[2], 18'd30);

        // "OSCIDY" header mismatch, then a valid width-2 frame.
        d0 = done_n; e0 = err_n;
        send_str("WAVWID");
        send_field(18'd5);
        send_str("OSCIDY");
        idle(3);
        check("hdr_err", err_n - e0, 1);
        check("hdr_err_lat", err_cyc - last_byte_cyc, 0);
        check("hdr_errcnt", error_count, 8'd1);
        check("hdr_done", done_n - d0, 0);
        check("hdr_width_kept", wave_width, 18'd1);
        check("hdr_osc_kept", osc_indices[0], 18'd10);
        send_head(18'd2, {18'd4, 18'd3, 18'd2, 18'd1});
        send_sample(18'd0, 16'hFFFF);
        send_sample(18'd1, 16'h0000);
        idle(4);
        check("hdr_next_done", done_n - d0, 1);
        check("hdr_next_width", wave_width, 18'd2);
        check("hdr_next_osc3", osc_indices[3], 18'd4);

        // Width first byte with bit 2 set.
        e0 = err_n;
        send_str("WAVWID");
        send_byte(8'h04);
        idle(3);
        check("fld_err", err_n - e0, 1);
        check("fld_err_lat", err_cyc - last_byte_cyc, 0);
        check("fld_errcnt", error_count, 8'd2);
        check("fld_width_kept", wave_width, 18'd2);

        // Width-0 frame: no strobes, done two cycles after the final 'T'.
        d0 = done_n; s0 = strobe_n;
        send_head(18'd0, {18'd9, 18'd8, 18'd7, 18'd6});
        idle(4);
        check("w0_done", done_n - d0, 1);
        check("w0_done_lat", done_cyc - last_byte_cyc, 1);
        check("w0_strobes", strobe_n - s0, 0);
        check("w0_width", wave_width, 18'd0);
        check("w0_osc1", osc_indices[1], 18'd7);

        // Stall inside the second sample pair.
        d0 = done_n; e0 = err_n;
        send_head(18'd2, {18'd1, 18'd1, 18'd1, 18'd1});
        send_sample(18'd0, 16'hC0DE);
        send_byte(8'h5A);
`ifdef BYTES_SCREEN_DECODER_TIMEOUT_EN
        idle(60);
        check("tmo_err", err_n - e0, 1);
        check("tmo_err_lat", err_cyc - last_byte_cyc, 50);
        check("tmo_done", done_n - d0, 0);
        check("tmo_errcnt", error_count, 8'd3);
        d0 = done_n; e0 = err_n;
        send_head(18'd2, {18'd1, 18'd1, 18'd1, 18'd1});
        send_sample(18'd0, 16'hC0DE);
        send_byte(8'h5A);
        idle(49);
        exp_q.push_back({18'd1, 16'h5AA5});
        send_byte(8'hA5);
        idle(4);
        check("tmo_edge_err", err_n - e0, 0);
        check("tmo_edge_done", done_n - d0, 1);
`else
        idle(200);
        check("stall_err", err_n - e0, 0);
        exp_q.push_back({18'd1, 16'h5AA5});
        send_byte(8'hA5);
        idle(4);
        check("stall_done", done_n - d0, 1);
        check("stall_errcnt", error_count, 8'd2);
`endif
        check("stall_q", exp_q.size(), 0);

        // Reset asserted mid-frame.
        d0 = done_n; e0 = err_n;
        send_head(18'd4, {18'd2, 18'd2, 18'd2, 18'd2});
        send_sample(18'd0, 16'h1111);
        send_byte(8'h22);
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_width", wave_width, 18'd0);
        check("mrst_osc", osc_indices, 72'd0);
        check("mrst_errcnt", error_count, 8'd0);
        idle(3);
        check("mrst_pulses", (done_n - d0) + (err_n - e0), 0);
        rst_n = 1'b1;
        idle(1);
        send_head(18'd1, {18'd5, 18'd6, 18'd7, 18'd8});
        send_sample(18'd0, 16'hBEEF);
        idle(4);
        check("mrst_next_done", done_n - d0, 1);
        check("mrst_next_width", wave_width, 18'd1);
        check("mrst_next_osc0", osc_indices[0], 18'd8);
        check("final_q", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
